// File: rtl/batcharger_ctrl_fsm.sv
// Battery charger control FSM: trickle -> constant current -> constant voltage -> done,
// with debounced transitions, CV timeout, temperature fault and recharge; outputs are registered.
module batcharger_ctrl_fsm #(
  parameter int ADC_W    = 10,
  parameter int DEB      = 3,
  parameter int TMR_W    = 16,
  parameter int TMAX_CV  = 50000,
  parameter int VCUTOFF  = 600,
  parameter int VFLOAT   = 840,
  parameter int VRECH    = 800,
  parameter int TEMP_LO  = 100,
  parameter int TEMP_HI  = 900,
  parameter int ICC_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       sel,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] vbat_code,
  input  logic [ADC_W-1:0] ibat_code,
  input  logic [ADC_W-1:0] vtemp_code,
  output logic [2:0]       state_o,
  output logic             tc,
  output logic             cc,
  output logic             cv,
  output logic             done,
  output logic             fault,
  output logic [ADC_W-1:0] iset_code,
  output logic [ADC_W-1:0] vset_code
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TC    = 3'd1,
    S_CC    = 3'd2,
    S_CV    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int IW = ADC_W + 5;
  localparam logic [IW-1:0] IMAX = {{5{1'b0}}, {ADC_W{1'b1}}};

  state_t           state, state_nx;
  logic [3:0]       deb_cnt, deb_nx;
  logic [TMR_W-1:0] cv_tmr, tmr_nx;

  logic [IW-1:0]    icc_w, itc_w, iend_w;
  logic [ADC_W-1:0] icc, itc, iend;
  logic [ADC_W-1:0] iset_nx, vset_nx;
  logic             temp_bad, exit_cond, hot;
  state_t           exit_tgt;

  // Setpoints derived from capacity, computed wide then clamped to the code range
  always_comb begin
    icc_w  = (IW'(sel) + IW'(1)) * IW'(ICC_STEP);
    itc_w  = icc_w >> 3;
    iend_w = icc_w >> 4;
    icc    = (icc_w  > IMAX) ? IMAX[ADC_W-1:0] : icc_w[ADC_W-1:0];
    itc    = (itc_w  > IMAX) ? IMAX[ADC_W-1:0] : itc_w[ADC_W-1:0];
    iend   = (iend_w > IMAX) ? IMAX[ADC_W-1:0] : iend_w[ADC_W-1:0];
  end

  always_comb begin
    temp_bad  = (vtemp_code < ADC_W'(TEMP_LO)) || (vtemp_code > ADC_W'(TEMP_HI));
    hot       = (state == S_TC) || (state == S_CC) || (state == S_CV);
    exit_cond = 1'b0;
    exit_tgt  = state;
    case (state)
      S_TC:    begin exit_cond = (vbat_code >= ADC_W'(VCUTOFF)); exit_tgt = S_CC;   end
      S_CC:    begin exit_cond = (vbat_code >= ADC_W'(VFLOAT));  exit_tgt = S_CV;   end
      S_CV:    begin exit_cond = (ibat_code <= iend);            exit_tgt = S_DONE; end
      S_DONE:  begin exit_cond = (vbat_code <  ADC_W'(VRECH));   exit_tgt = S_CC;   end
      S_FAULT: begin exit_cond = !temp_bad;                      exit_tgt = S_IDLE; end
      default: begin exit_cond = 1'b0;                           exit_tgt = state;  end
    endcase
  end

  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    if (!en) begin
      state_nx = S_IDLE;
    end else if (state == S_IDLE) begin
      state_nx = S_TC;
    end else if (hot && sample_valid && temp_bad) begin
      state_nx = S_FAULT;
    end else if ((state == S_CV) && (cv_tmr == TMR_W'(TMAX_CV - 1))) begin
      state_nx = S_DONE;
    end else if (sample_valid) begin
      if (exit_cond) begin
        if (deb_cnt == 4'(DEB - 1)) state_nx = exit_tgt;
        else                        deb_nx   = deb_cnt + 4'd1;
      end else begin
        deb_nx = 4'd0;
      end
    end
    if (state_nx != state) deb_nx = 4'd0;

    // Timer counts only while staying in CV, so entering CV always starts it at zero
    tmr_nx = '0;
    if ((state == S_CV) && (state_nx == S_CV))
      tmr_nx = (cv_tmr == {TMR_W{1'b1}}) ? cv_tmr : cv_tmr + 1'b1;

    iset_nx = '0;
    vset_nx = '0;
    case (state_nx)
      S_TC:       iset_nx = itc;
      S_CC, S_CV: begin iset_nx = icc; vset_nx = ADC_W'(VFLOAT); end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      deb_cnt   <= 4'd0;
      cv_tmr    <= '0;
      state_o   <= 3'd0;
      tc        <= 1'b0;
      cc        <= 1'b0;
      cv        <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      iset_code <= '0;
      vset_code <= '0;
    end else begin
      state     <= state_nx;
      deb_cnt   <= deb_nx;
      cv_tmr    <= tmr_nx;
      state_o   <= state_nx;
      tc        <= (state_nx == S_TC);
      cc        <= (state_nx == S_CC);
      cv        <= (state_nx == S_CV);
      done      <= (state_nx == S_DONE);
      fault     <= (state_nx == S_FAULT);
      iset_code <= iset_nx;
      vset_code <= vset_nx;
    end
  end

endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// Directed charge-cycle scenarios followed by random traffic, all checked against a behavioural model.
module tb_batcharger_ctrl_fsm;
  localparam int TMAX = 50000;

  logic       clk = 1'b0;
  logic       rst, en, sample_valid;
  logic [3:0] sel;
  logic [9:0] vbat_code, ibat_code, vtemp_code;
  logic [2:0] state_o;
  logic       tc, cc, cv, done, fault;
  logic [9:0] iset_code, vset_code;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode number, run of qualifying samples, edge index of CV entry
  int m_state = 0;
  int m_streak = 0;
  int m_cv_entry = 0;
  int m_sel = 0;
  int edge_idx = 0;

  batcharger_ctrl_fsm dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .sample_valid(sample_valid),
    .vbat_code(vbat_code), .ibat_code(ibat_code), .vtemp_code(vtemp_code),
    .state_o(state_o), .tc(tc), .cc(cc), .cv(cv), .done(done), .fault(fault),
    .iset_code(iset_code), .vset_code(vset_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cap_icc(input int s);
    int v;
    v = (s + 1) * 8;
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic model_edge();
    int nxt;
    int icc;
    bit qual;
    int tgt;
    icc = cap_icc(int'(sel));
    nxt = m_state;
    qual = 1'b0;
    tgt = m_state;
    case (m_state)
      1: begin qual = (vbat_code >= 600);     tgt = 2; end
      2: begin qual = (vbat_code >= 840);     tgt = 3; end
      3: begin qual = (ibat_code <= icc / 16); tgt = 4; end
      4: begin qual = (vbat_code < 800);      tgt = 2; end
      5: begin qual = (vtemp_code >= 100 && vtemp_code <= 900); tgt = 0; end
      default: ;
    endcase
    if (rst || !en) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state >= 1 && m_state <= 3 && sample_valid && (vtemp_code < 100 || vtemp_code > 900)) nxt = 5;
    else if (m_state == 3 && (edge_idx - m_cv_entry) == TMAX) nxt = 4;
    else if (sample_valid) begin
      if (qual) begin
        m_streak++;
        if (m_streak == 3) nxt = tgt;
      end else m_streak = 0;
    end
    if (rst || nxt != m_state) m_streak = 0;
    if (nxt == 3 && m_state != 3) m_cv_entry = edge_idx;
    m_state = rst ? 0 : nxt;
    m_sel = rst ? 0 : int'(sel);
  endtask

  task automatic check_outputs();
    int icc;
    int exp_iset;
    icc = cap_icc(m_sel);
    exp_iset = (m_state == 1) ? icc / 8 : ((m_state == 2 || m_state == 3) ? icc : 0);
    chk("state", 32'(state_o), 32'(m_state));
    chk("tc", 32'(tc), 32'(m_state == 1));
    chk("cc", 32'(cc), 32'(m_state == 2));
    chk("cv", 32'(cv), 32'(m_state == 3));
    chk("done", 32'(done), 32'(m_state == 4));
    chk("fault", 32'(fault), 32'(m_state == 5));
    chk("iset", 32'(iset_code), 32'(exp_iset));
    chk("vset", 32'(vset_code), (m_state == 2 || m_state == 3) ? 32'd840 : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    edge_idx++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic samp(input logic [9:0] v, input logic [9:0] i, input logic [9:0] t);
    sample_valid = 1'b1;
    vbat_code = v;
    ibat_code = i;
    vtemp_code = t;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    int cvk;
    rst = 1'b1; en = 1'b1; sel = 4'b1000; sample_valid = 1'b0;
    vbat_code = 10'd500; ibat_code = 10'd50; vtemp_code = 10'd500;
    repeat (3) step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_iset", 32'(iset_code), 32'd0);
    chk("rst_deb", 32'(dut.deb_cnt), 32'd0);
    chk("rst_tmr", 32'(dut.cv_tmr), 32'd0);

    rst = 1'b0;
    step();
    chk("tc_entry", 32'(state_o), 32'd1);
    chk("tc_iset", 32'(iset_code), 32'd9);
    repeat (3) samp(10'd600, 10'd50, 10'd500);
    chk("cc_entry", 32'(state_o), 32'd2);
    chk("cc_iset", 32'(iset_code), 32'd72);
    chk("cc_vset", 32'(vset_code), 32'd840);

    samp(10'd850, 10'd50, 10'd500);
    samp(10'd850, 10'd50, 10'd500);
    samp(10'd700, 10'd50, 10'd500);
    samp(10'd850, 10'd50, 10'd500);
    samp(10'd850, 10'd50, 10'd500);
    chk("cc_hold_after_break", 32'(state_o), 32'd2);
    samp(10'd850, 10'd50, 10'd500);
    chk("cv_entry", 32'(cv), 32'd1);
    chk("cc_cv_exclusive", 32'(cc & cv), 32'd0);

    repeat (3) samp(10'd840, 10'd4, 10'd500);
    chk("done_entry", 32'(done), 32'd1);
    chk("done_iset", 32'(iset_code), 32'd0);
    repeat (3) samp(10'd800, 10'd4, 10'd500);
    chk("vrech_equal_stays", 32'(state_o), 32'd4);
    repeat (3) samp(10'd799, 10'd4, 10'd500);
    chk("recharge_cc", 32'(state_o), 32'd2);

    repeat (3) samp(10'd850, 10'd50, 10'd500);
    chk("cv_again", 32'(state_o), 32'd3);
    cvk = -1;
    for (int k = 1; k <= 60000; k++) begin
      sample_valid = 1'($urandom_range(0, 1));
      step();
      if (done) begin cvk = k; break; end
    end
    sample_valid = 1'b0;
    chk("cv_timeout_cycles", 32'(cvk), 32'(TMAX));

    repeat (3) samp(10'd799, 10'd50, 10'd500);
    chk("cc_from_done", 32'(state_o), 32'd2);
    samp(10'd700, 10'd50, 10'd950);
    chk("temp_fault", 32'(fault), 32'd1);
    repeat (3) samp(10'd700, 10'd50, 10'd500);
    chk("fault_to_idle", 32'(state_o), 32'd0);
    step();
    chk("idle_to_tc", 32'(state_o), 32'd1);
    samp(10'd600, 10'd50, 10'd500);
    samp(10'd600, 10'd50, 10'd500);
    en = 1'b0;
    samp(10'd600, 10'd50, 10'd500);
    chk("en_low_wins", 32'(state_o), 32'd0);
    en = 1'b1;

    step();
    repeat (3) samp(10'd600, 10'd50, 10'd500);
    repeat (3) samp(10'd850, 10'd50, 10'd500);
    repeat (2) samp(10'd850, 10'd4, 10'd500);
    chk("cv_mid_debounce", 32'(state_o), 32'd3);
    rst = 1'b1;
    samp(10'd850, 10'd4, 10'd500);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_iset", 32'(iset_code), 32'd0);
    chk("midrst_vset", 32'(vset_code), 32'd0);
    chk("midrst_deb", 32'(dut.deb_cnt), 32'd0);
    chk("midrst_tmr", 32'(dut.cv_tmr), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_tc", 32'(state_o), 32'd1);
    repeat (3) samp(10'd600, 10'd50, 10'd500);
    repeat (3) samp(10'd850, 10'd50, 10'd500);
    chk("post_rst_tmr", 32'(dut.cv_tmr), 32'd0);
    repeat (2) samp(10'd850, 10'd4, 10'd500);
    chk("deb_restarted", 32'(state_o), 32'd3);
    samp(10'd850, 10'd4, 10'd500);
    chk("deb_third", 32'(state_o), 32'd4);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 49) != 0);
      sample_valid = 1'($urandom_range(0, 1));
      vbat_code = 10'($urandom_range(560, 880));
      ibat_code = 10'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0)
        vtemp_code = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 99)) : 10'($urandom_range(901, 1023));
      else
        vtemp_code = 10'($urandom_range(100, 900));
      if ($urandom_range(0, 15) == 0) sel = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
